// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes, bit-period helper.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Clock cycles per serial bit (integer division). A zero baud rate yields 0 so the
  // caller's N<2 check rejects it instead of dividing by zero during elaboration.
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return (baud > 0) ? (clk_hz / baud) : 0;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick on the last cycle of every bit period while enabled.
// Latency: tick in the CyclesPerBit-th cycle after enable rises, then every CyclesPerBit.
// Backpressure: none; enable=0 holds the counter at zero.
// Ports: clock (rising edge), reset (async active-low), enable (count), tick (period end).
module uart_baud_tick #(
  parameter int CyclesPerBit = 104
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CntW = (CyclesPerBit > 2) ? $clog2(CyclesPerBit) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CyclesPerBit - 1);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            wrap;

  always_comb begin
    cnt_d = '0;
    wrap  = 1'b0;
    if (enable) begin
      wrap  = (cnt_q == CntLast);
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = wrap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Latency: start bit begins the cycle after a request is accepted; frame lasts F*N cycles.
// Backpressure: requests ignored while busy, except in the done cycle (gapless chaining).
// Ports: clock, reset (async active-low), startTransmission/data (request + payload),
//        busy (frame in progress), done (1-cycle end pulse), tx (registered serial line).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int DataBits       = 8,
  parameter int Parity         = 0,
  parameter int StopBits       = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                startTransmission,
  input  logic [DataBits-1:0] data,
  output logic                busy,
  output logic                done,
  output logic                tx
);

  localparam int N = cycles_per_bit(ClockFrequency, BaudRate);

  generate
    if (N < 2 || DataBits < 5 || DataBits > 9 || Parity < PARITY_NONE ||
        Parity > PARITY_EVEN || StopBits < 1 || StopBits > 2) begin : g_bad_param
      $error("uart_tx_frame: illegal parameters (bit period or range)");
    end
  endgenerate

  localparam logic [3:0] LastData = 4'(DataBits - 1);
  localparam logic [3:0] LastStop = 4'(StopBits - 1);

  tx_state_e           state_q, state_d;
  logic [DataBits-1:0] data_q, data_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
  logic                tick;
  logic                accept;
  logic                parity_bit;

  uart_baud_tick #(
    .CyclesPerBit(N)
  ) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .enable(busy),
    .tick  (tick)
  );

  assign busy = (state_q != IDLE);
  // done is decoded from registered state only, so it is clean for a full cycle.
  assign done = (state_q == STOP) && tick && (bit_cnt_q == LastStop);
  assign accept = startTransmission && (!busy || done);
  // Odd mode: total ones (data + parity) odd; even mode: total ones even.
  assign parity_bit = (Parity == PARITY_ODD) ? ~(^data_q) : (^data_q);
  assign tx = tx_q;

  // data_q keeps the accepted payload untouched for the whole frame (parity source);
  // shift_q is a working copy that presents the next data bit at shift_q[0].
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d   = START;
          tx_d      = 1'b0;
          data_d    = data;
          shift_d   = data;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            if (Parity != PARITY_NONE) begin
              state_d = PARITY;
              tx_d    = parity_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            bit_cnt_d = '0;
            if (accept) begin
              // Chained request: next start bit follows with no idle cycle.
              state_d = START;
              tx_d    = 1'b0;
              data_d  = data;
              shift_d = data;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        tx_d      = 1'b1;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 7N2) at N=10 cycles/bit.
// Expected per-cycle tx/busy/done values are queued when a request is driven and
// popped one per cycle on the falling clock edge.
module tb_uart_tx_frame;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int NBIT   = CLK_HZ / BAUD;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } exp_t;

  logic       clock;
  logic       rst_n;
  logic [3:0] start_r;
  logic [8:0] data_r [4];
  logic [3:0] tx_w;
  logic [3:0] busy_w;
  logic [3:0] done_w;

  int cfg_db  [4] = '{8, 8, 8, 7};
  int cfg_par [4] = '{0, 2, 1, 0};
  int cfg_sb  [4] = '{1, 1, 1, 2};

  exp_t sb[$];
  int   n_asserts;
  int   n_fail;
  int   cyc;

  uart_tx_frame #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataBits(8), .Parity(0), .StopBits(1))
  u_dut_8n1 (.clock(clock), .reset(rst_n), .startTransmission(start_r[0]), .data(data_r[0][7:0]),
             .busy(busy_w[0]), .done(done_w[0]), .tx(tx_w[0]));

  uart_tx_frame #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataBits(8), .Parity(2), .StopBits(1))
  u_dut_8e1 (.clock(clock), .reset(rst_n), .startTransmission(start_r[1]), .data(data_r[1][7:0]),
             .busy(busy_w[1]), .done(done_w[1]), .tx(tx_w[1]));

  uart_tx_frame #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataBits(8), .Parity(1), .StopBits(1))
  u_dut_8o1 (.clock(clock), .reset(rst_n), .startTransmission(start_r[2]), .data(data_r[2][7:0]),
             .busy(busy_w[2]), .done(done_w[2]), .tx(tx_w[2]));

  uart_tx_frame #(.ClockFrequency(CLK_HZ), .BaudRate(BAUD), .DataBits(7), .Parity(0), .StopBits(2))
  u_dut_7n2 (.clock(clock), .reset(rst_n), .startTransmission(start_r[3]), .data(data_r[3][6:0]),
             .busy(busy_w[3]), .done(done_w[3]), .tx(tx_w[3]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void push_idle(int n);
    exp_t e;
    e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  // Reference frame built bit by bit from the payload and the instance's format.
  function automatic void push_frame(int dut, logic [8:0] d);
    logic bits[$];
    int   ones;
    exp_t e;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[dut]; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_par[dut] == 1) bits.push_back((ones % 2) == 0);
    if (cfg_par[dut] == 2) bits.push_back((ones % 2) == 1);
    for (int i = 0; i < cfg_sb[dut]; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < NBIT; k++) begin
        e.tx   = bits[b];
        e.busy = 1'b1;
        e.done = (b == bits.size() - 1) && (k == NBIT - 1);
        sb.push_back(e);
      end
    end
  endfunction

  task automatic check(int dut, string tag);
    exp_t e;
    if (sb.size() == 0) begin
      e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0;
    end else begin
      e = sb.pop_front();
    end
    n_asserts++;
    assert (tx_w[dut] === e.tx) else begin
      n_fail++;
      $error("FAIL %s tx dut=%0d cyc=%0d observed=%b expected=%b", tag, dut, cyc, tx_w[dut], e.tx);
    end
    n_asserts++;
    assert (busy_w[dut] === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy dut=%0d cyc=%0d observed=%b expected=%b", tag, dut, cyc, busy_w[dut], e.busy);
    end
    n_asserts++;
    assert (done_w[dut] === e.done) else begin
      n_fail++;
      $error("FAIL %s done dut=%0d cyc=%0d observed=%b expected=%b", tag, dut, cyc, done_w[dut], e.done);
    end
  endtask

  // One cycle: compare on the falling edge, then drop any single-cycle request.
  task automatic run(int dut, int n, string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      check(dut, tag);
      start_r = '0;
    end
  endtask

  // Raise a request now (between edges); the next rising edge is cycle 0.
  task automatic start_req(int dut, logic [8:0] d, bit expect_accept);
    start_r[dut] = 1'b1;
    data_r[dut]  = d;
    if (expect_accept) begin
      push_frame(dut, d);
      cyc = 0;
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    start_r   = '0;
    for (int i = 0; i < 4; i++) data_r[i] = '0;

    // Reset state of every instance.
    repeat (3) @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      push_idle(1);
      check(d, "reset");
    end
    rst_n = 1'b1;
    push_idle(2);
    run(0, 2, "idle");

    // 8N1, 0xA5.
    start_req(0, 9'h0A5, 1'b1);
    run(0, 100, "8n1_a5");
    push_idle(3);
    run(0, 3, "8n1_tail");

    // 8E1 and 8O1, 0x07: parity bit 1 and 0 respectively, done at cycle 110.
    start_req(1, 9'h007, 1'b1);
    run(1, 110, "8e1_07");
    push_idle(3);
    run(1, 3, "8e1_tail");
    start_req(2, 9'h007, 1'b1);
    run(2, 110, "8o1_07");
    push_idle(3);
    run(2, 3, "8o1_tail");

    // 7N2, 0x55: two stop bits, busy drops after cycle 100.
    start_req(3, 9'h055, 1'b1);
    run(3, 100, "7n2_55");
    push_idle(3);
    run(3, 3, "7n2_tail");

    // Back-to-back: second request accepted in the done cycle.
    start_req(0, 9'h012, 1'b1);
    run(0, 100, "b2b_12");
    start_req(0, 9'h034, 1'b1);
    run(0, 100, "b2b_34");
    push_idle(3);
    run(0, 3, "b2b_tail");

    // Mid-frame request is ignored; frame keeps its original payload.
    start_req(0, 9'h03C, 1'b1);
    run(0, 50, "ign_3c");
    start_req(0, 9'h0FF, 1'b0);
    run(0, 50, "ign_3c");
    push_idle(3);
    run(0, 3, "ign_tail");

    // Reset mid-frame at cycle 35: immediate idle outputs, no done pulse.
    start_req(0, 9'h0F0, 1'b1);
    run(0, 35, "rst_f0");
    rst_n = 1'b0;
    sb.delete();
    #1;
    push_idle(1);
    check(0, "rst_async");
    push_idle(3);
    run(0, 3, "rst_hold");
    // Release and request together: first edge after release must accept.
    rst_n = 1'b1;
    start_req(0, 9'h0FF, 1'b1);
    run(0, 100, "post_rst_ff");
    push_idle(3);
    run(0, 3, "post_rst_tail");

    n_asserts++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
